// File: rtl/xadc_drp_sequencer.sv
// rtl/xadc_drp_sequencer.sv - XADC DRP EMG/ECG read sequencer; define ADC_AVG_EN for 4-round averaging
module xadc_drp_sequencer #(
    parameter logic [6:0] EMG_ADDR       = 7'h13,
    parameter logic [6:0] ECG_ADDR       = 7'h1B,
    parameter int         TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        eoc_in,
    output logic [6:0]  drp_daddr,
    output logic        drp_den,
    output logic        drp_dwe,
    output logic [15:0] drp_di,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy,
    output logic [31:0] emg_out,
    output logic [31:0] ecg_out,
    output logic        sample_valid,
    output logic        busy,
    input  logic        err_clr,
    output logic        timeout_err,
    output logic        overrun_err
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ_EMG, S_WAIT_EMG, S_REQ_ECG, S_WAIT_ECG, S_DONE
    } state_t;

    state_t        r_state, w_next;
    logic [CW-1:0] r_wait_cnt, w_wait_inc;
    logic          r_pending, r_emg_got, r_sample_valid, r_timeout_err, r_overrun_err;
    logic [11:0]   r_emg_code, r_emg_val, r_ecg_val, w_emg_new, w_ecg_new;
    logic          w_den, w_is_wait, w_expired, w_cap_emg, w_cap_ecg;
    logic          w_to_event, w_ov_event, w_leave_idle, w_to_done;
    logic [3:0]    w_unused_do_lsbs;

`ifdef ADC_AVG_EN
    logic [1:0]    r_round;
    logic [13:0]   r_emg_sum, r_ecg_sum, w_emg_sum, w_ecg_sum;
    assign w_emg_sum = r_emg_sum + {2'b00, w_emg_new};
    assign w_ecg_sum = r_ecg_sum + {2'b00, w_ecg_new};
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    assign w_is_wait  = (r_state == S_WAIT_EMG) || (r_state == S_WAIT_ECG);
    assign w_wait_inc = r_wait_cnt + CW'(1);
    // Counter includes the current WAIT cycle, so the window is exactly TIMEOUT_CYCLES long.
    assign w_expired  = (w_wait_inc == CW'(TIMEOUT_CYCLES));

    always_comb begin
        w_next     = r_state;
        w_den      = 1'b0;
        w_cap_emg  = 1'b0;
        w_cap_ecg  = 1'b0;
        w_to_event = 1'b0;
        case (r_state)
            S_IDLE:     if (enable && (eoc_in || r_pending)) w_next = S_REQ_EMG;
            S_REQ_EMG:  begin w_den = 1'b1; w_next = S_WAIT_EMG; end
            S_WAIT_EMG: begin
                if (drp_drdy) begin
                    w_cap_emg = 1'b1;
                    w_next    = S_REQ_ECG;
                end else if (w_expired) begin
                    w_to_event = 1'b1;
                    w_next     = S_REQ_ECG;
                end
            end
            S_REQ_ECG:  begin w_den = 1'b1; w_next = S_WAIT_ECG; end
            S_WAIT_ECG: begin
                if (drp_drdy) begin
                    w_cap_ecg = 1'b1;
                    w_next    = S_DONE;
                end else if (w_expired) begin
                    w_to_event = 1'b1;
                    w_next     = S_DONE;
                end
            end
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    assign w_leave_idle     = (r_state == S_IDLE) && (w_next == S_REQ_EMG);
    assign w_to_done        = (r_state == S_WAIT_ECG) && (w_next == S_DONE);
    assign w_ov_event       = eoc_in && (r_state != S_IDLE) && r_pending;
    // A channel that timed out re-presents its previous output value.
    assign w_emg_new        = r_emg_got ? r_emg_code : r_emg_val;
    assign w_ecg_new        = w_cap_ecg ? drp_do[15:4] : r_ecg_val;
    assign w_unused_do_lsbs = drp_do[3:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt     <= '0;
            r_pending      <= 1'b0;
            r_emg_got      <= 1'b0;
            r_emg_code     <= '0;
            r_emg_val      <= '0;
            r_ecg_val      <= '0;
            r_sample_valid <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_overrun_err  <= 1'b0;
`ifdef ADC_AVG_EN
            r_round        <= '0;
            r_emg_sum      <= '0;
            r_ecg_sum      <= '0;
`endif
        end else begin
            r_wait_cnt     <= w_is_wait ? w_wait_inc : '0;
            r_timeout_err  <= w_to_event | (r_timeout_err & ~err_clr);
            r_overrun_err  <= w_ov_event | (r_overrun_err & ~err_clr);
            r_sample_valid <= 1'b0;
            if (w_leave_idle)
                r_pending <= 1'b0;
            else if (eoc_in && (r_state != S_IDLE))
                r_pending <= 1'b1;
            if (w_leave_idle)
                r_emg_got <= 1'b0;
            else if (w_cap_emg) begin
                r_emg_got  <= 1'b1;
                r_emg_code <= drp_do[15:4];
            end
            if (w_to_done) begin
`ifdef ADC_AVG_EN
                r_round <= r_round + 2'd1;
                if (r_round == 2'd3) begin
                    r_emg_val      <= w_emg_sum[13:2];
                    r_ecg_val      <= w_ecg_sum[13:2];
                    r_emg_sum      <= '0;
                    r_ecg_sum      <= '0;
                    r_sample_valid <= 1'b1;
                end else begin
                    r_emg_sum <= w_emg_sum;
                    r_ecg_sum <= w_ecg_sum;
                end
`else
                r_emg_val      <= w_emg_new;
                r_ecg_val      <= w_ecg_new;
                r_sample_valid <= 1'b1;
`endif
            end
        end
    end

    assign drp_den      = w_den;
    assign drp_daddr    = ((r_state == S_REQ_ECG) || (r_state == S_WAIT_ECG)) ? ECG_ADDR : EMG_ADDR;
    assign drp_dwe      = 1'b0;
    assign drp_di       = '0;
    assign emg_out      = {20'h0, r_emg_val};
    assign ecg_out      = {20'h0, r_ecg_val};
    assign sample_valid = r_sample_valid;
    assign busy         = (r_state != S_IDLE);
    assign timeout_err  = r_timeout_err;
    assign overrun_err  = r_overrun_err;
endmodule

// File: tb/tb_xadc_drp_sequencer.sv
// tb/tb_xadc_drp_sequencer.sv - cycle-scheduled round model and reactive DRP responder for xadc_drp_sequencer
module tb_xadc_drp_sequencer;
    localparam int MAXC = 400;
    localparam int TMO  = 64;
    localparam logic [6:0] A_EMG = 7'h13;
    localparam logic [6:0] A_ECG = 7'h1B;

    logic        clk = 1'b0;
    logic        reset = 1'b1, enable = 1'b1, eoc_in = 1'b0, err_clr = 1'b0;
    logic        drp_drdy = 1'b0;
    logic [15:0] drp_do = 16'h0;
    logic [6:0]  drp_daddr;
    logic        drp_den, drp_dwe, sample_valid, busy, timeout_err, overrun_err;
    logic [15:0] drp_di;
    logic [31:0] emg_out, ecg_out;

    xadc_drp_sequencer dut (
        .clk(clk), .reset(reset), .enable(enable), .eoc_in(eoc_in),
        .drp_daddr(drp_daddr), .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_di(drp_di),
        .drp_do(drp_do), .drp_drdy(drp_drdy),
        .emg_out(emg_out), .ecg_out(ecg_out), .sample_valid(sample_valid),
        .busy(busy), .err_clr(err_clr), .timeout_err(timeout_err), .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // stimulus schedule, indexed by cycle
    bit          drv_rst [MAXC];
    bit          drv_eoc [MAXC];
    bit          drv_clr [MAXC];
    bit          drv_en  [MAXC];
    bit          drv_spur[MAXC];
    int          plan_delay[MAXC];
    logic [15:0] plan_data [MAXC];

    // expected timeline; fields: 0 emg code, 1 ecg code, 2 timeout_err, 3 overrun_err
    bit          exp_busy[MAXC];
    bit          exp_den [MAXC];
    bit          exp_valid[MAXC];
    bit          exp_care[MAXC];
    logic [6:0]  exp_addr[MAXC];
    int          exp_f[4][MAXC];

    int m_emg, m_ecg, m_sum_e, m_sum_c, m_cnt;
    int n_cmp = 0, n_fail = 0, n_valid_final = 0;
    int sched = -1;
    logic [15:0] sched_data = 16'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic fill(input int f, input int c, input int v);
        for (int i = c; i < MAXC; i++) exp_f[f][i] = v;
    endtask

    // One round whose IDLE exit decision happens in cycle n; de/dc = drdy delay after den (0 = never).
    task automatic model_round(input int n, input int de, input int dc,
                               input logic [15:0] doe, input logic [15:0] doc, output int d);
        int re, rc, we, wc, ce, cc;
        bit te, tc;
        te = (de == 0);
        tc = (dc == 0);
        we = te ? TMO : de;
        wc = tc ? TMO : dc;
        re = n + 1;
        rc = re + we + 1;
        d  = rc + wc + 1;
        plan_delay[re] = de; plan_data[re] = doe;
        plan_delay[rc] = dc; plan_data[rc] = doc;
        for (int c = re; c <= d; c++) begin
            exp_busy[c] = 1'b1;
            exp_den[c]  = (c == re) || (c == rc);
            exp_care[c] = (c < d);
            exp_addr[c] = (c < rc) ? A_EMG : A_ECG;
        end
        if (te) fill(2, rc, 1);
        if (tc) fill(2, d, 1);
        ce = te ? m_emg : int'(doe[15:4]);
        cc = tc ? m_ecg : int'(doc[15:4]);
`ifdef ADC_AVG_EN
        m_sum_e += ce;
        m_sum_c += cc;
        m_cnt++;
        if (m_cnt == 4) begin
            m_emg = m_sum_e / 4;
            m_ecg = m_sum_c / 4;
            m_sum_e = 0; m_sum_c = 0; m_cnt = 0;
            exp_valid[d] = 1'b1;
            fill(0, d, m_emg);
            fill(1, d, m_ecg);
        end
`else
        m_emg = ce;
        m_ecg = cc;
        exp_valid[d] = 1'b1;
        fill(0, d, m_emg);
        fill(1, d, m_ecg);
`endif
    endtask

    task automatic model_reset(input int c);
        drv_rst[c] = 1'b1;
        for (int i = c + 1; i < MAXC; i++) begin
            exp_busy[i] = 1'b0; exp_den[i] = 1'b0; exp_valid[i] = 1'b0; exp_care[i] = 1'b0;
        end
        for (int f = 0; f < 4; f++) fill(f, c + 1, 0);
        m_emg = 0; m_ecg = 0; m_sum_e = 0; m_sum_c = 0; m_cnt = 0;
    endtask

    task automatic model_clear(input int c);
        drv_clr[c] = 1'b1;
        fill(2, c + 1, 0);
        fill(3, c + 1, 0);
    endtask

    task automatic at(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // input driver
    initial forever begin
        @(posedge clk);
        #1;
        if (cyc < MAXC) begin
            reset   = drv_rst[cyc];
            enable  = drv_en[cyc];
            eoc_in  = drv_eoc[cyc];
            err_clr = drv_clr[cyc];
            if (drv_spur[cyc]) begin
                drp_drdy = 1'b1; drp_do = 16'hFFF0;
            end else if (cyc == sched) begin
                drp_drdy = 1'b1; drp_do = sched_data;
            end else begin
                drp_drdy = 1'b0; drp_do = 16'($urandom);
            end
        end
    end

    // DRP responder reacts to the den the DUT actually issues
    initial forever begin
        @(negedge clk);
        if (cyc < MAXC && drp_den === 1'b1 && plan_delay[cyc] > 0) begin
            sched      = cyc + plan_delay[cyc];
            sched_data = plan_data[cyc];
        end
    end

    // per-cycle compare against the model timeline
    initial forever begin
        @(negedge clk);
        if (cyc >= 1 && cyc < MAXC) begin
            chk("busy", 32'(busy), 32'(exp_busy[cyc]));
            chk("drp_den", 32'(drp_den), 32'(exp_den[cyc]));
            chk("drp_dwe", 32'(drp_dwe), 32'h0);
            chk("drp_di", 32'(drp_di), 32'h0);
            if (exp_care[cyc]) chk("drp_daddr", 32'(drp_daddr), 32'(exp_addr[cyc]));
            chk("sample_valid", 32'(sample_valid), 32'(exp_valid[cyc]));
            chk("emg_out", emg_out, 32'(exp_f[0][cyc]));
            chk("ecg_out", ecg_out, 32'(exp_f[1][cyc]));
            chk("timeout_err", 32'(timeout_err), 32'(exp_f[2][cyc]));
            chk("overrun_err", 32'(overrun_err), 32'(exp_f[3][cyc]));
            if (cyc > 350 && sample_valid === 1'b1) n_valid_final++;
        end
    end

    initial begin
        int d;
        for (int i = 0; i < MAXC; i++) begin
            drv_rst[i] = 0; drv_eoc[i] = 0; drv_clr[i] = 0; drv_en[i] = 1; drv_spur[i] = 0;
            plan_delay[i] = 0; plan_data[i] = 16'h0;
            exp_busy[i] = 0; exp_den[i] = 0; exp_valid[i] = 0; exp_care[i] = 0; exp_addr[i] = A_EMG;
            for (int f = 0; f < 4; f++) exp_f[f][i] = 0;
        end
        m_emg = 0; m_ecg = 0; m_sum_e = 0; m_sum_c = 0; m_cnt = 0;
        drv_rst[1] = 1; drv_rst[2] = 1;
        // reset while waiting for EMG; its drdy lands after reset
        drv_eoc[6] = 1; model_round(6, 2, 1, 16'h7770, 16'h8880, d); model_reset(8);
        drv_spur[12] = 1;
        drv_eoc[15] = 1; model_round(15, 1, 1, 16'hABC0, 16'h1230, d);
        drv_eoc[25] = 1; model_round(25, 3, 5, 16'h5A5F, 16'h0010, d);
        drv_eoc[40] = 1; model_round(40, 2, 0, 16'h3C30, 16'h9990, d);
        model_clear(115);
        drv_eoc[120] = 1; model_round(120, 64, 1, 16'hFED0, 16'h0000, d);
        drv_eoc[195] = 1; drv_eoc[197] = 1;
        model_round(195, 1, 1, 16'h1110, 16'h2220, d); model_round(d + 1, 1, 1, 16'h3330, 16'h4440, d);
        drv_eoc[215] = 1; drv_eoc[217] = 1; drv_eoc[218] = 1;
        model_round(215, 1, 1, 16'h0120, 16'h0340, d); fill(3, 219, 1);
        model_round(d + 1, 2, 1, 16'h0560, 16'h0780, d);
        drv_eoc[235] = 1; drv_eoc[237] = 1;
        for (int c = 236; c < 260; c++) drv_en[c] = 0;
        model_round(235, 1, 1, 16'h0AA0, 16'h0BB0, d); model_round(260, 1, 1, 16'h0CC0, 16'h0DD0, d);
        model_clear(270);
        model_clear(340);
        drv_eoc[275] = 1; model_round(275, 0, 1, 16'h5550, 16'h6660, d);
        model_reset(350);
        for (int k = 0; k < 4; k++) begin
            drv_eoc[355 + 10 * k] = 1;
            model_round(355 + 10 * k, 1, 1, 16'((100 + 2 * k) << 4), 16'((4 + 4 * k) << 4), d);
        end

        at(2);   chk("lit reset busy", 32'(busy), 32'h0); chk("lit reset daddr", 32'(drp_daddr), 32'h13);
                 chk("lit reset den", 32'(drp_den), 32'h0); chk("lit reset emg", emg_out, 32'h0);
        at(9);   chk("lit midreset busy", 32'(busy), 32'h0); chk("lit midreset den", 32'(drp_den), 32'h0);
                 chk("lit midreset emg", emg_out, 32'h0); chk("lit midreset ecg", ecg_out, 32'h0);
        at(16);  chk("lit den emg", 32'(drp_den), 32'h1); chk("lit addr emg", 32'(drp_daddr), 32'h13);
        at(18);  chk("lit den ecg", 32'(drp_den), 32'h1); chk("lit addr ecg", 32'(drp_daddr), 32'h1B);
`ifndef ADC_AVG_EN
        at(20);  chk("lit valid N+5", 32'(sample_valid), 32'h1);
                 chk("lit emg ABC", emg_out, 32'h0000_0ABC); chk("lit ecg 123", ecg_out, 32'h0000_0123);
`endif
        at(108); chk("lit to before", 32'(timeout_err), 32'h0);
        at(109); chk("lit to set", 32'(timeout_err), 32'h1);
`ifndef ADC_AVG_EN
                 chk("lit to valid", 32'(sample_valid), 32'h1); chk("lit to ecg kept", ecg_out, 32'h1);
`endif
        at(116); chk("lit to cleared", 32'(timeout_err), 32'h0);
        at(188); chk("lit drdy at last wait", 32'(timeout_err), 32'h0);
        at(218); chk("lit ov before", 32'(overrun_err), 32'h0);
        at(219); chk("lit ov set", 32'(overrun_err), 32'h1);
        at(250); chk("lit enable0 idle", 32'(busy), 32'h0);
        at(261); chk("lit pending after enable", 32'(drp_den), 32'h1);
        at(271); chk("lit ov cleared", 32'(overrun_err), 32'h0);
        at(341); chk("lit clr vs event", 32'(timeout_err), 32'h1);
        at(391);
`ifdef ADC_AVG_EN
        chk("lit avg emg", emg_out, 32'd103); chk("lit avg ecg", ecg_out, 32'd10);
        chk("lit avg valid count", 32'(n_valid_final), 32'd1);
`else
        chk("lit last emg", emg_out, 32'd106); chk("lit last ecg", ecg_out, 32'd16);
        chk("lit valid count", 32'(n_valid_final), 32'd4);
`endif
        at(MAXC);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/xadc_drp_sequencer.md
XADC_DRP_SEQUENCER -- requirements
Module: xadc_drp_sequencer

Interface
REQ-001 SHALL have parameter EMG_ADDR, default 7'h13, DRP address of VAUX3 (EMG) status register.
REQ-002 SHALL have parameter ECG_ADDR, default 7'h1B, DRP address of VAUX11 (ECG) status register.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64, max cycles from den pulse to drdy before abort.
REQ-004 SHALL have ports: clk  in  1  sole clock; reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports: enable  in  1  sequencing allowed; eoc_in  in  1  XADC end-of-conversion pulse.
REQ-006 SHALL have ports: drp_daddr  out  7  DRP address; drp_den  out  1  DRP enable; drp_dwe  out  1  write enable (constant 0); drp_di  out  16  write data (constant 0).
REQ-007 SHALL have ports: drp_do  in  16  DRP read data; drp_drdy  in  1  DRP data ready.
REQ-008 SHALL have ports: emg_out  out  32  EMG sample; ecg_out  out  32  ECG sample; sample_valid  out  1  one-cycle pulse when both outputs are updated.
REQ-009 SHALL have ports: busy  out  1  FSM not IDLE; err_clr  in  1  clears sticky errors; timeout_err  out  1  sticky; overrun_err  out  1  sticky.

Function
REQ-010 SHALL implement FSM states IDLE, REQ_EMG, WAIT_EMG, REQ_ECG, WAIT_ECG, DONE.
REQ-011 IDLE -> REQ_EMG when enable=1 and (eoc_in=1 or pending=1); consumes pending.
REQ-012 REQ_x SHALL drive drp_den=1 for exactly one cycle with drp_daddr=EMG_ADDR or ECG_ADDR; drp_den=0 in all other states.
REQ-013 drp_daddr SHALL hold the current channel address from REQ_x through WAIT_x.
REQ-014 WAIT_x SHALL exit on drp_drdy=1 (capture drp_do[15:4]) or when wait counter reaches TIMEOUT_CYCLES (set timeout_err, no capture).
REQ-015 WAIT_EMG -> REQ_ECG; WAIT_ECG -> DONE; DONE -> IDLE after one cycle.
REQ-016 Captured 12-bit code SHALL be zero-extended: out = {20'h0, code}.
REQ-017 Outputs SHALL update and sample_valid SHALL pulse in DONE; a channel that timed out keeps its previous value.
REQ-018 Latency: eoc_in at cycle N, drdy same cycle as each den+1 -> den at N+1 and N+3, sample_valid at N+5.
REQ-019 eoc_in while not IDLE SHALL set one-deep pending flag; eoc_in while pending already set SHALL set overrun_err.
REQ-020 drp_drdy in IDLE, REQ_x or DONE SHALL be ignored.
REQ-021 enable=0 SHALL block leaving IDLE only; an in-progress round completes.
REQ-022 err_clr SHALL clear both sticky errors; an error event in the same cycle takes priority (stays set).

Reset
REQ-023 reset SHALL force state IDLE, drp_den=0, drp_daddr=EMG_ADDR, pending=0, wait counter=0.
REQ-024 reset SHALL clear emg_out, ecg_out, sample_valid, timeout_err, overrun_err, busy and any averaging state.
REQ-025 reset mid-transaction SHALL abandon it; a later stale drp_drdy SHALL be ignored.

Configuration
REQ-026 Macro ADC_AVG_EN defined: each channel SHALL accumulate 4 rounds' codes (14-bit sums); outputs = {20'h0, sum[13:2]}; sample_valid every 4th DONE; sums cleared after update; a timed-out channel SHALL contribute its previous output value.
REQ-027 ADC_AVG_EN undefined: no accumulator logic; outputs and sample_valid per REQ-017 every round.

Verification
REQ-028 Reset, eoc_in pulse, drdy 1 cycle after each den, drp_do 16'hABC0 then 16'h1230 -> emg_out=32'h0000_0ABC, ecg_out=32'h0000_0123, sample_valid at N+5.
REQ-029 eoc_in, ECG drdy withheld -> timeout_err=1 after 64 WAIT_ECG cycles, ecg_out unchanged, sample_valid still pulses; err_clr -> 0.
REQ-030 Two eoc_in pulses during one round -> second round runs from pending, overrun_err=0; three -> overrun_err=1.
REQ-031 reset asserted during WAIT_EMG, stale drdy next cycle -> outputs remain 0, state IDLE, drp_den=0.
REQ-032 ADC_AVG_EN, EMG codes 100,102,104,106 over 4 rounds -> single sample_valid, emg_out=32'd103.
